d_latch_checker: RTL



---
 rtl/d_latch_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/d_latch_checker.sv
// ----------------------------------------------------------------------------
// d_latch_checker
//
// Purpose:
//   Observation-side monitor for a D latch under test. On every rising edge of
//   i_clk it samples the latch enable, data input and both latch outputs. It
//   keeps a reference model of the value the latch should be storing. After
//   each expected change it waits a programmable number of edges before it
//   checks Q again. Each check compares Q against the model and confirms that
//   Qp is the complement of Q. Pass and error statistics are accumulated.
//
// Parameters:
//   SETTLE  sampling edges skipped after an expected change (legal 1..15)
//   CNT_W   width of the pass / error counters
//
// Ports:
//   i_clk         sampling clock, all state updates on its rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          latch-under-test enable (transparent when 1)
//   i_d           latch-under-test data input
//   i_q           latch true output
//   i_qp          latch complement output
//   o_err         registered mismatch flag, one cycle per failing check
//   o_fail        sticky mismatch flag, cleared only by reset
//   o_state       monitor state: 00 unknown, 01 settling, 10 check
//   o_err_count   saturating count of failing checks
//   o_pass_count  saturating count of passing checks
// ----------------------------------------------------------------------------
module d_latch_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_d,
    input  logic             i_q,
    input  logic             i_qp,
    output logic             o_err,
    output logic             o_fail,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_pass_count
);

    typedef enum logic [1:0] {
        StUnknown  = 2'b00,
        StSettling = 2'b01,
        StCheck    = 2'b10
    } state_e;

    localparam logic [3:0]       SettleLoad = 4'(SETTLE);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           r_state;
    logic [3:0]       r_cnt;
    logic             r_exp;
    logic             r_exp_valid;
    logic             r_err;
    logic             r_fail;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_pass_count;

    logic w_trigger;
    logic w_check;
    logic w_mismatch;

    // An expected change: the latch is open and its stored value is about to
    // become defined or different from the model.
    assign w_trigger  = i_en && (!r_exp_valid || (i_d != r_exp));
    // Trigger edges are never checked: a transparent latch may already show
    // the new value there.
    assign w_check    = (r_state == StCheck) && !w_trigger;
    assign w_mismatch = (i_q != r_exp) || (i_qp == i_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StUnknown;
            r_cnt        <= 4'd0;
            r_exp        <= 1'b0;
            r_exp_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_fail       <= 1'b0;
            r_err_count  <= '0;
            r_pass_count <= '0;
        end else begin
            // Reference model follows D while the latch is open, holds otherwise.
            if (i_en) begin
                r_exp       <= i_d;
                r_exp_valid <= 1'b1;
            end

            if (w_trigger) begin
                // Restarts the settle window from any state, SETTLING included.
                r_state <= StSettling;
                r_cnt   <= SettleLoad;
            end else begin
                case (r_state)
                    StUnknown: r_state <= StUnknown;
                    StSettling: begin
                        if (r_cnt == 4'd1) begin
                            r_state <= StCheck;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    StCheck:   r_state <= StCheck;
                    default:   r_state <= StUnknown;
                endcase
            end

            r_err <= 1'b0;
            if (w_check) begin
                if (w_mismatch) begin
                    r_err  <= 1'b1;
                    r_fail <= 1'b1;
                    if (r_err_count != CntMax) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                end else if (r_pass_count != CntMax) begin
                    r_pass_count <= r_pass_count + 1'b1;
                end
            end
        end
    end

    assign o_err        = r_err;
    assign o_fail       = r_fail;
    assign o_state      = r_state;
    assign o_err_count  = r_err_count;
    assign o_pass_count = r_pass_count;

endmodule
